// File: rtl/dmem_sched.sv
// Data-memory scheduler: round-robin arbitration of C cores onto one memory
// port, with optional short ownership locks and a one-cycle read-return path.
module dmem_sched #(
    parameter int C       = 8,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MAXHOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [C-1:0]          req,
    input  logic [C-1:0]          we,
    input  logic [C-1:0]          lk,
    input  logic [C-1:0][AW-1:0]  adr,
    input  logic [C-1:0][DW-1:0]  wdat,
    output logic [C-1:0]          gnt,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_adr,
    output logic [DW-1:0]         mem_wdat,
    input  logic [DW-1:0]         mem_rdata,
    output logic [C-1:0]          rvalid,
    output logic [DW-1:0]         rdata
);

    localparam int unsigned CU   = C;
    localparam int          PW   = $clog2(C);
    localparam logic [3:0]  HMAX = 4'(MAXHOLD - 1);

    typedef enum logic {ARB, HOLD} state_t;

    state_t          state, state_d;
    logic [PW-1:0]   ptr, ptr_d;
    logic [PW-1:0]   owner, owner_d;
    logic [3:0]      hcnt, hcnt_d;
    logic [PW-1:0]   sel;
    logic            sel_vld;
    logic [PW-1:0]   scan;

    // Grant selection and next-state: rotating scan in ARB, owner-only in HOLD.
    // ptr is left untouched in HOLD; it already points at owner+1 from entry.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        owner_d = owner;
        hcnt_d  = hcnt;
        sel     = '0;
        sel_vld = 1'b0;
        scan    = '0;
        unique case (state)
            ARB: begin
                for (int unsigned k = 0; k < CU; k++) begin
                    scan = PW'((32'(ptr) + k) % CU);
                    if (!sel_vld && req[scan]) begin
                        sel     = scan;
                        sel_vld = 1'b1;
                    end
                end
                if (sel_vld) begin
                    ptr_d = PW'((32'(sel) + 32'd1) % CU);
                    if (lk[sel] && (MAXHOLD > 1)) begin
                        owner_d = sel;
                        hcnt_d  = 4'd1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                sel     = owner;
                sel_vld = req[owner];
                if (req[owner] && lk[owner] && (hcnt < HMAX)) begin
                    hcnt_d = hcnt + 4'd1;
                end else begin
                    hcnt_d  = '0;
                    state_d = ARB;
                end
            end
        endcase
        if (reset) begin
            sel_vld = 1'b0;
        end
    end

    // Memory-side outputs: granted core's fields, all zero when idle.
    always_comb begin
        gnt      = '0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_adr  = '0;
        mem_wdat = '0;
        if (sel_vld) begin
            gnt[sel] = 1'b1;
            mem_en   = 1'b1;
            mem_we   = we[sel];
            mem_adr  = adr[sel];
            mem_wdat = wdat[sel];
        end
    end

    // Read data is passed through while a read return is flagged.
    always_comb begin
        rdata = (|rvalid) ? mem_rdata : '0;
    end

    // State registers and the one-cycle read-valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ARB;
            ptr    <= '0;
            owner  <= '0;
            hcnt   <= '0;
            rvalid <= '0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            owner  <= owner_d;
            hcnt   <= hcnt_d;
            rvalid <= gnt & ~we;
        end
    end

endmodule

// File: tb/tb_dmem_sched.sv
// Self-checking bench for dmem_sched: directed vector table, hand-written
// read/write sequences, then randomized traffic against a behavioural model.
module tb_dmem_sched;

    localparam int C       = 8;
    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int MAXHOLD = 4;

    logic                 clk;
    logic                 reset;
    logic [C-1:0]         req, we, lk;
    logic [C-1:0][AW-1:0] adr;
    logic [C-1:0][DW-1:0] wdat;
    logic [C-1:0]         gnt;
    logic                 mem_en, mem_we;
    logic [AW-1:0]        mem_adr;
    logic [DW-1:0]        mem_wdat;
    logic [DW-1:0]        mem_rdata;
    logic [C-1:0]         rvalid;
    logic [DW-1:0]        rdata;

    dmem_sched #(.C(C), .AW(AW), .DW(DW), .MAXHOLD(MAXHOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .lk(lk),
        .adr(adr), .wdat(wdat), .gnt(gnt), .mem_en(mem_en), .mem_we(mem_we),
        .mem_adr(mem_adr), .mem_wdat(mem_wdat), .mem_rdata(mem_rdata),
        .rvalid(rvalid), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: who may be served next, and how many grants the
    // current lock holder has had.
    int        m_ptr, m_owner, m_cnt;
    bit        m_hold;
    logic [7:0] m_rv;
    bit        m_rv_known;

    typedef struct packed {
        logic [7:0]  gnt;
        logic [7:0]  rv;
        logic        en;
        logic        we;
        logic [15:0] adr;
        logic [15:0] wdat;
        logic [15:0] rdata;
    } samp_t;

    // One clock cycle: inputs are already set (at negedge); check at +1,
    // advance the model at posedge, return at the next negedge.
    task automatic cycle(output samp_t s);
        int g;
        logic [7:0] eg;
        #1;
        g = -1;
        if (!reset) begin
            if (m_hold) begin
                if (req[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < C; k++) begin
                    int j;
                    j = (m_ptr + k) % C;
                    if (g < 0 && req[j]) g = j;
                end
            end
        end
        s.gnt = gnt; s.rv = rvalid; s.en = mem_en; s.we = mem_we;
        s.adr = mem_adr; s.wdat = mem_wdat; s.rdata = rdata;
        eg = (g >= 0) ? 8'(1 << g) : 8'h00;
        check("gnt", 32'(gnt), 32'(eg));
        check("mem_en", 32'(mem_en), (g >= 0) ? 32'd1 : 32'd0);
        check("mem_we", 32'(mem_we), (g >= 0) ? 32'(we[g]) : 32'd0);
        check("mem_adr", 32'(mem_adr), (g >= 0) ? 32'(adr[g]) : 32'd0);
        check("mem_wdat", 32'(mem_wdat), (g >= 0) ? 32'(wdat[g]) : 32'd0);
        if (m_rv_known) begin
            check("rvalid", 32'(rvalid), 32'(m_rv));
            if (m_rv != 8'h00) check("rdata", 32'(rdata), 32'(mem_rdata));
        end
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_owner = 0; m_cnt = 0; m_hold = 0;
            m_rv = 8'h00; m_rv_known = 1;
        end else begin
            m_rv = (g >= 0 && !we[g]) ? 8'(1 << g) : 8'h00;
            m_rv_known = 1;
            if (m_hold) begin
                if (g >= 0) m_cnt++;
                if (g < 0 || !lk[m_owner] || m_cnt >= MAXHOLD) begin
                    m_hold = 0;
                    m_cnt  = 0;
                end
            end else if (g >= 0) begin
                m_ptr = (g + 1) % C;
                if (lk[g] && MAXHOLD > 1) begin
                    m_hold  = 1;
                    m_owner = g;
                    m_cnt   = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] we;
        logic [7:0] lk;
        logic [7:0] exp_gnt;
        logic       chk_rv;
        logic [7:0] exp_rv;
    } vec_t;

    vec_t  tbl[$];
    samp_t s;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_hold = 0; m_rv = 8'h00; m_rv_known = 0;
        reset = 1'b1; req = '0; we = '0; lk = '0; mem_rdata = '0;
        for (int i = 0; i < C; i++) begin
            adr[i]  = 16'(16'h1000 + i * 16'h0101);
            wdat[i] = 16'(16'hA000 + i);
        end

        // Round-robin from reset, hold-limit, early lock release, reset in HOLD.
        tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00});
        for (int i = 0; i < 9; i++)
            tbl.push_back('{1'b0, 8'hFF, 8'hFF, 8'h00, 8'(1 << (i % 8)), 1'b1, 8'h00});
        tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{1'b0, 8'h24, 8'hFF, 8'h04, 8'h04, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 8'h24, 8'hFF, 8'h04, 8'h20, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 8'h04, 8'hFF, 8'h04, 8'h04, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 8'h02, 8'hFF, 8'h02, 8'h02, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 8'h03, 8'hFF, 8'h02, 8'h02, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 8'h03, 8'hFF, 8'h00, 8'h02, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 8'h03, 8'hFF, 8'h00, 8'h01, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 8'h04, 8'h00, 8'h04, 8'h04, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 8'h04, 8'h00, 8'h04, 8'h04, 1'b1, 8'h04});
        tbl.push_back('{1'b1, 8'h04, 8'h00, 8'h04, 8'h00, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 8'hFF, 8'hFF, 8'h00, 8'h01, 1'b1, 8'h00});

        @(negedge clk);
        foreach (tbl[i]) begin
            reset = tbl[i].rst; req = tbl[i].req; we = tbl[i].we; lk = tbl[i].lk;
            mem_rdata = 16'($urandom);
            cycle(s);
            check($sformatf("tbl%0d_gnt", i), 32'(s.gnt), 32'(tbl[i].exp_gnt));
            if (tbl[i].chk_rv) check($sformatf("tbl%0d_rvalid", i), 32'(s.rv), 32'(tbl[i].exp_rv));
        end

        // Single read from core 3 returning BEEF.
        reset = 1'b1; req = '0; we = '0; lk = '0;
        cycle(s);
        reset = 1'b0; req = 8'h08; we = 8'h00; adr[3] = 16'h0040;
        cycle(s);
        check("rd_gnt", 32'(s.gnt), 32'h08);
        check("rd_en", 32'(s.en), 32'd1);
        check("rd_we", 32'(s.we), 32'd0);
        check("rd_adr", 32'(s.adr), 32'h0040);
        req = 8'h00; mem_rdata = 16'hBEEF;
        cycle(s);
        check("rd_rvalid", 32'(s.rv), 32'h08);
        check("rd_rdata", 32'(s.rdata), 32'hBEEF);
        check("idle_en", 32'(s.en), 32'd0);
        check("idle_adr", 32'(s.adr), 32'd0);

        // Single write from core 6: no read return afterwards.
        req = 8'h40; we = 8'h40; adr[6] = 16'h0010; wdat[6] = 16'h1234;
        cycle(s);
        check("wr_en", 32'(s.en), 32'd1);
        check("wr_we", 32'(s.we), 32'd1);
        check("wr_adr", 32'(s.adr), 32'h0010);
        check("wr_wdat", 32'(s.wdat), 32'h1234);
        req = 8'h00; we = 8'h00;
        cycle(s);
        check("wr_rvalid", 32'(s.rv), 32'h00);

        // Back-to-back reads from several cores.
        req = 8'h0F; we = 8'h00; lk = 8'h00;
        for (int i = 0; i < 5; i++) begin
            mem_rdata = 16'($urandom);
            cycle(s);
        end

        // Randomized traffic: locks biased on so HOLD is exercised.
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            req   = 8'($urandom) & 8'($urandom | $urandom);
            we    = 8'($urandom);
            lk    = 8'($urandom | $urandom);
            mem_rdata = 16'($urandom);
            for (int i = 0; i < C; i++) begin
                adr[i]  = 16'($urandom);
                wdat[i] = 16'($urandom);
            end
            cycle(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
